// File: rtl/frankie_mem_arbiter.sv
// Arbitrates the single-ported main memory between the CPU datapath and the IO/loader port.
// Three-cycle serialised access with a starvation limit that guarantees IO progress.
module frankie_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  logic [1:0]        state;
  logic [3:0]        starve_cnt;
  logic              rd;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] io_hold;
  logic              io_win;
  logic              any_req;

  assign any_req = cpu_req | io_req;
  assign io_win  = io_req & (~cpu_req | (starve_cnt == LIMIT));

  // Read data is forwarded from memory during the done cycle, then held.
  assign cpu_rdata = (cpu_done & rd) ? mem_rdata : cpu_hold;
  assign io_rdata  = (io_done & rd) ? mem_rdata : io_hold;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      rd         <= 1'b0;
      cpu_hold   <= '0;
      io_hold    <= '0;
      cpu_done   <= 1'b0;
      io_done    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      io_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (!io_req || io_win)
            starve_cnt <= 4'd0;
          else if (starve_cnt < LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
          if (any_req) begin
            mem_en    <= 1'b1;
            mem_we    <= io_win ? io_we : cpu_we;
            mem_addr  <= io_win ? io_addr : cpu_addr;
            mem_wdata <= io_win ? io_wdata : cpu_wdata;
            rd        <= io_win ? ~io_we : ~cpu_we;
            owner     <= io_win;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          cpu_done <= ~owner;
          io_done  <= owner;
          state    <= RESP;
        end
        RESP: begin
          if (cpu_done && rd)
            cpu_hold <= mem_rdata;
          if (io_done && rd)
            io_hold <= mem_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frankie_mem_arbiter.sv
// Randomised and directed bench for frankie_mem_arbiter.
// A transaction-level model predicts every output cycle by cycle.
module tb_frankie_mem_arbiter;

  localparam int LIM = 4;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    logic        own;
    logic [15:0] rd;
    int          lat;
  } cl_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic [15:0] cpu_rdata, io_rdata;
  logic        cpu_done, io_done;
  logic        mem_en, mem_we, owner;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  always #5 CLK = ~CLK;

  frankie_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIM)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .io_req(io_req), .io_we(io_we),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_done(io_done),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // Synchronous memory the arbiter drives
  logic [15:0] ram [0:1023];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Model state
  logic [15:0] gold [0:1023];
  int          slot, starve;
  logic        m_rd;
  logic        e_en, e_we, e_owner, e_cdone, e_idone;
  logic [15:0] e_addr, e_wdata, e_crd, e_ird;
  logic        glog [$];
  cl_t         clog [$];

  // Requester state
  txn_t cq [$];
  txn_t iq [$];
  logic c_act, i_act, io_mask;
  int   c_iss, i_iss;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s cyc %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic check_outputs();
    compared++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !==
        {e_en, e_we, e_addr, e_wdata}) begin
      mismatched++;
      $display("FAIL mem cyc %0d: got en=%b we=%b a=%h d=%h want en=%b we=%b a=%h d=%h",
               cyc, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
    end
    compared++;
    if ({cpu_done, io_done, owner} !== {e_cdone, e_idone, e_owner}) begin
      mismatched++;
      $display("FAIL ctl cyc %0d: got cdone=%b idone=%b own=%b want %b %b %b",
               cyc, cpu_done, io_done, owner, e_cdone, e_idone, e_owner);
    end
    compared++;
    if ({cpu_rdata, io_rdata} !== {e_crd, e_ird}) begin
      mismatched++;
      $display("FAIL rdata cyc %0d: got crd=%h ird=%h want %h %h",
               cyc, cpu_rdata, io_rdata, e_crd, e_ird);
    end
  endtask

  task automatic drive();
    txn_t t;
    if (e_cdone) begin
      clog.push_back('{1'b0, cpu_rdata, cyc - c_iss});
      c_act = 1'b0;
    end
    if (e_idone) begin
      clog.push_back('{1'b1, io_rdata, cyc - i_iss});
      i_act = 1'b0;
    end
    if (!c_act && cq.size() > 0) begin
      t = cq.pop_front();
      cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
      c_act = 1'b1; c_iss = cyc;
    end
    if (!i_act && iq.size() > 0) begin
      t = iq.pop_front();
      io_we = t.we; io_addr = t.addr; io_wdata = t.wdata;
      i_act = 1'b1; i_iss = cyc;
    end
    cpu_req = c_act;
    io_req  = i_act & ~io_mask;
  endtask

  task automatic model_zero();
    slot = 0; starve = 0; m_rd = 1'b0;
    e_en = 0; e_we = 0; e_owner = 0; e_cdone = 0; e_idone = 0;
    e_addr = '0; e_wdata = '0; e_crd = '0; e_ird = '0;
  endtask

  // Predicts the outputs for the next cycle from the inputs just driven
  task automatic model();
    logic iow;
    if (!Reset) begin
      model_zero();
      return;
    end
    e_en = 0; e_we = 0; e_cdone = 0; e_idone = 0;
    if (slot == 0) begin
      iow = io_req && (!cpu_req || starve == LIM);
      if (!io_req || iow) starve = 0;
      else if (starve < LIM) starve++;
      if (cpu_req || io_req) begin
        e_en    = 1'b1;
        e_we    = iow ? io_we : cpu_we;
        e_addr  = iow ? io_addr : cpu_addr;
        e_wdata = iow ? io_wdata : cpu_wdata;
        e_owner = iow;
        m_rd    = !e_we;
        glog.push_back(iow);
        if (e_we) gold[e_addr[9:0]] = e_wdata;
        slot = 1;
      end
    end else if (slot == 1) begin
      if (e_owner) e_idone = 1'b1;
      else e_cdone = 1'b1;
      if (m_rd && e_owner) e_ird = gold[e_addr[9:0]];
      if (m_rd && !e_owner) e_crd = gold[e_addr[9:0]];
      slot = 2;
    end else begin
      slot = 0;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    check_outputs();
    drive();
    model();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(string name, int bound);
    int n = 0;
    while ((c_act || i_act || cq.size() > 0 || iq.size() > 0) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) begin
      compared++;
      mismatched++;
      $display("FAIL %s cyc %0d: still busy after %0d cycles, want idle", name, cyc, bound);
    end
  endtask

  function automatic txn_t mk(logic we, logic [15:0] a, logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc %0d: bench did not finish", cyc);
    $fatal(1);
  end

  initial begin
    int n, nc;
    logic [9:0] obs;
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_we = 0; io_addr = 0; io_wdata = 0;
    c_act = 0; i_act = 0; io_mask = 0; c_iss = 0; i_iss = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]  = 16'(i * 40503) ^ 16'h5A5A;
      gold[i] = ram[i];
    end
    ram[10'h010] = 16'hBEEF; gold[10'h010] = 16'hBEEF;
    ram[10'h020] = 16'hAAAA; gold[10'h020] = 16'hAAAA;
    ram[10'h021] = 16'h5555; gold[10'h021] = 16'h5555;
    ram[10'h030] = 16'hC0DE; gold[10'h030] = 16'hC0DE;
    model_zero();
    #2 Reset = 1'b0;
    #1;
    chk("reset_outputs",
        {mem_en, mem_we, cpu_done, io_done, owner, mem_addr, mem_wdata},
        32'h0);
    chk("reset_rdata", {cpu_rdata, io_rdata}, 32'h0);
    run(2);
    Reset = 1'b1;

    // Lone CPU read
    clog.delete();
    cq.push_back(mk(1'b0, 16'h0010, 16'h0));
    run(6);
    chk("t1_count", 32'(clog.size()), 32'd1);
    if (clog.size() > 0) begin
      chk("t1_owner", {31'b0, clog[0].own}, 32'd0);
      chk("t1_rdata", {16'b0, clog[0].rd}, 32'hBEEF);
      chk("t1_latency", 32'(clog[0].lat), 32'd2);
    end

    // IO write, then CPU reads it back
    clog.delete();
    iq.push_back(mk(1'b1, 16'h0200, 16'h1234));
    run_until_idle("t2_io", 20);
    cq.push_back(mk(1'b0, 16'h0200, 16'h0));
    run_until_idle("t2_cpu", 20);
    chk("t2_count", 32'(clog.size()), 32'd2);
    if (clog.size() == 2) begin
      chk("t2_io_owner", {31'b0, clog[0].own}, 32'd1);
      chk("t2_readback", {16'b0, clog[1].rd}, 32'h1234);
    end

    // Continuous contention: four CPU grants per IO grant
    glog.delete();
    for (int i = 0; i < 10; i++) begin
      cq.push_back(mk(1'b0, 16'(i), 16'h0));
      iq.push_back(mk(1'b0, 16'(100 + i), 16'h0));
    end
    n = 0;
    while (glog.size() < 10 && n < 100) begin step(); n++; end
    obs = '0;
    for (int i = 0; i < 10 && i < glog.size(); i++) obs[i] = glog[i];
    chk("t3_grant_order", {22'b0, obs}, {22'b0, 10'b1000010000});
    cq.delete();
    iq.delete();
    run_until_idle("t3_drain", 100);

    // IO withdraws after two CPU grants; counter must restart
    glog.delete();
    for (int i = 0; i < 20; i++) cq.push_back(mk(1'b0, 16'(200 + i), 16'h0));
    iq.push_back(mk(1'b0, 16'h0300, 16'h0));
    n = 0;
    while (glog.size() < 2 && n < 50) begin step(); n++; end
    io_mask = 1'b1;
    run(9);
    io_mask = 1'b0;
    n = glog.size();
    nc = 0;
    while (n < glog.size() + 1 && nc < 60) begin
      step();
      nc++;
      if (glog.size() > n && glog[glog.size() - 1]) break;
    end
    nc = 0;
    for (int i = n; i < glog.size(); i++) if (!glog[i]) nc++;
    chk("t4_cpu_before_io", 32'(nc), 32'd4);
    cq.delete();
    run_until_idle("t4_drain", 100);

    // Read data held per requester
    cq.push_back(mk(1'b0, 16'h0020, 16'h0));
    run_until_idle("t6_cpu", 20);
    iq.push_back(mk(1'b0, 16'h0021, 16'h0));
    run_until_idle("t6_io", 20);
    run(2);
    chk("t6_cpu_rdata", {16'b0, cpu_rdata}, 32'hAAAA);
    chk("t6_io_rdata", {16'b0, io_rdata}, 32'h5555);

    // Reset during ACCESS of a CPU read
    clog.delete();
    cq.push_back(mk(1'b0, 16'h0030, 16'h0));
    run(2);
    chk("t5_access_en", {31'b0, mem_en}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    chk("t5_async_drop", {29'b0, mem_en, mem_we, cpu_done}, 32'd0);
    c_act = 0; cq.delete(); cpu_req = 0;
    model();
    run(3);
    Reset = 1'b1;
    chk("t5_no_done", 32'(clog.size()), 32'd0);
    cq.push_back(mk(1'b0, 16'h0030, 16'h0));
    run_until_idle("t5_reissue", 20);
    chk("t5_count", 32'(clog.size()), 32'd1);
    if (clog.size() > 0) chk("t5_rdata", {16'b0, clog[0].rd}, 32'hC0DE);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if (!c_act && cq.size() == 0 && $urandom_range(3) == 0)
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          cq.push_back(mk(1'($urandom_range(1)), 16'($urandom_range(63)), 16'($urandom)));
      if (!i_act && iq.size() == 0 && $urandom_range(3) == 0)
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          iq.push_back(mk(1'($urandom_range(1)), 16'($urandom_range(63)), 16'($urandom)));
      step();
    end
    run_until_idle("rand_drain", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
